// File: rtl/tinyqv_data_arbiter.sv
// tinyqv_data_arbiter: shares the memory controller data port between a
// priority CPU port (A) and a low-priority DMA/debug port (B), with a
// starvation guard that forces a B grant after STARVE_LIMIT A grants.
module tinyqv_data_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic [24:0] a_addr,
    input  logic [1:0]  a_write_n,
    input  logic [1:0]  a_read_n,
    input  logic [31:0] a_wdata,
    output logic        a_ready,
    output logic [31:0] a_rdata,

    input  logic [24:0] b_addr,
    input  logic [1:0]  b_write_n,
    input  logic [1:0]  b_read_n,
    input  logic [31:0] b_wdata,
    output logic        b_ready,
    output logic [31:0] b_rdata,

    output logic [24:0] mem_addr,
    output logic [1:0]  mem_write_n,
    output logic [1:0]  mem_read_n,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;
    logic       a_req, b_req;

    assign a_req = (a_read_n & a_write_n) != 2'b11;
    assign b_req = (b_read_n & b_write_n) != 2'b11;

    // State and starvation counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Arbitration and counter update; grants only start from IDLE, which
    // guarantees one parked cycle between back-to-back transactions
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        case (state)
            IDLE: begin
                if (b_req && (!a_req || starve_cnt == LIMIT)) begin
                    state_nxt      = GNT_B;
                    starve_cnt_nxt = '0;
                end else if (a_req) begin
                    state_nxt = GNT_A;
                    if (b_req && starve_cnt != LIMIT)
                        starve_cnt_nxt = starve_cnt + 4'd1;
                end
                if (!b_req)
                    starve_cnt_nxt = '0;
            end
            GNT_A, GNT_B: begin
                if (mem_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port mux: parked in IDLE, owner's live inputs when granted
    always_comb begin
        mem_addr    = '0;
        mem_write_n = '1;
        mem_read_n  = '1;
        mem_wdata   = '0;
        owner       = 2'b00;
        case (state)
            GNT_A: begin
                mem_addr    = a_addr;
                mem_write_n = a_write_n;
                mem_read_n  = a_read_n;
                mem_wdata   = a_wdata;
                owner       = 2'b01;
            end
            GNT_B: begin
                mem_addr    = b_addr;
                mem_write_n = b_write_n;
                mem_read_n  = b_read_n;
                mem_wdata   = b_wdata;
                owner       = 2'b10;
            end
            default: ;
        endcase
    end

    // Ready routing; mem_ready seen in IDLE is dropped
    always_comb begin
        a_ready = mem_ready && (state == GNT_A);
        b_ready = mem_ready && (state == GNT_B);
    end

    assign a_rdata = mem_rdata;
    assign b_rdata = mem_rdata;

endmodule

// File: doc/tinyqv_data_arbiter.md
Name: tinyqv_data_arbiter

Overview:
- Shares the single data port of the memory controller (QSPI flash/RAM) between two masters.
  - Port A: CPU load/store unit, priority requester.
  - Port B: secondary master (DMA / debug), low priority.
- Registered grant FSM with a starvation guard for B.
- Sits between the requesters and the memory controller's data_addr / data_read_n / data_write_n / data_to_write / data_ready / data_from_read interface.

Parameters:
- STARVE_LIMIT, 4: consecutive A grants while B is pending before B is forced to win (1..15).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- a_addr  in  25  port A byte address.
- a_write_n  in  2  port A write size: 11 none, 00 byte, 01 half, 10 word.
- a_read_n  in  2  port A read size, same encoding.
- a_wdata  in  32  port A write data.
- a_ready  out  1  port A transaction complete pulse.
- a_rdata  out  32  port A read data.
- b_addr  in  25  port B byte address.
- b_write_n  in  2  port B write size.
- b_read_n  in  2  port B read size.
- b_wdata  in  32  port B write data.
- b_ready  out  1  port B transaction complete pulse.
- b_rdata  out  32  port B read data.
- mem_addr  out  25  to memory controller data_addr.
- mem_write_n  out  2  to memory controller data_write_n.
- mem_read_n  out  2  to memory controller data_read_n.
- mem_wdata  out  32  to memory controller data_to_write.
- mem_ready  in  1  from memory controller data_ready.
- mem_rdata  in  32  from memory controller data_from_read.
- owner  out  2  01 = A granted, 10 = B granted, 00 = idle.

Behaviour:
- Request definition: X requests when (x_read_n & x_write_n) != 2'b11. A requester holds its request stable until its ready pulse.
- States: IDLE, GNT_A, GNT_B. Single state register, async reset to IDLE.
- Reset values:
  - owner = 00, starve counter = 0.
  - mem_read_n = mem_write_n = 11, mem_addr = 0, mem_wdata = 0.
  - a_ready = b_ready = 0.
- IDLE:
  - Outputs are parked: mem_read_n = mem_write_n = 11, mem_addr = 0, mem_wdata = 0.
  - Arbitration, evaluated each cycle:
    - If B requests and (A idle or starve counter == STARVE_LIMIT), go to GNT_B.
    - Else if A requests, go to GNT_A.
    - Else stay in IDLE.
- GNT_A / GNT_B:
  - mem_* outputs are a combinational mux of the owner's inputs.
  - Stay in the state until mem_ready = 1, then return to IDLE next cycle.
  - The non-owner's request is ignored. Its ready stays 0.
- Ready routing:
  - a_ready = mem_ready & (state == GNT_A).
  - b_ready = mem_ready & (state == GNT_B).
  - mem_ready in IDLE is ignored and must not pulse either ready.
- Read data: a_rdata = b_rdata = mem_rdata (shared wires); only valid alongside the port's ready.
- Latency:
  - Request at cycle n in IDLE; grant and mem_* drive from cycle n+1.
  - Ready is the same cycle as mem_ready.
  - Back-to-back transactions always have exactly one IDLE cycle with mem_read_n/mem_write_n = 11. This is mandatory: the memory controller starts a new transaction on any non-11 size when not busy.
- Starve counter (4 bits, saturating at STARVE_LIMIT):
  - Increments on each IDLE to GNT_A transition while B is requesting.
  - Clears on IDLE to GNT_B.
  - Clears in any cycle where B is not requesting and the state is IDLE.
- Owner dropping its request before mem_ready:
  - Grant is held anyway until mem_ready, since the memory controller completes the transaction.
  - Outputs follow the owner's live inputs; the requester is in protocol violation, and the bench flags it.
- Simultaneous A and B requests with counter < STARVE_LIMIT: A wins.
- Async reset asserted mid-transaction:
  - Immediate return to IDLE and parked outputs.
  - Counter cleared.
  - The memory controller is reset by the same rstn.

Test Plan:
- A-only word read at 0x000100, mem_ready after 10 cycles -> owner = 01 from cycle 1; a_ready pulses once with a_rdata = mem_rdata = 0xDEADBEEF; b_ready stays 0; one IDLE cycle follows.
- A and B request in the same cycle, counter 0 -> A granted first; after A's ready, one IDLE cycle; then B granted; b_ready pulses with B's data.
- A requests continuously and B is pending throughout, STARVE_LIMIT = 4 -> grant sequence A, A, A, A, B, A...; counter reads 4 before the B grant and 0 after.
- B byte write (b_write_n = 00, b_wdata = 0x000000A5, b_addr = 0x1000003) -> mem_write_n = 00, mem_addr = 0x1000003, mem_wdata = 0xA5 during GNT_B; mem_read_n = 11 throughout.
- rstn pulsed low mid-GNT_B -> same cycle owner = 00, mem_read_n = mem_write_n = 11; after release with no requests, stays in IDLE.
- Spurious mem_ready in IDLE -> a_ready = b_ready = 0 and the state is unchanged.
